// File: rtl/cv32e40p_obi_instr_responder.sv
// cv32e40p_obi_instr_responder
//
// OBI instruction-fetch responder backed by a single-port synchronous-read
// SRAM. Grant and response latencies are programmable at run time so the
// prefetch buffer and aligner can be pushed into their corner cases.
// Fetches outside the SRAM window complete with a bus-error response.
//
// Ports
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   instr_req_i       OBI request
//   instr_addr_i      OBI byte address (bits [1:0] ignored)
//   instr_gnt_o       OBI grant
//   instr_rvalid_o    OBI response valid, one cycle per granted transfer
//   instr_rdata_o     response data (0 when not valid or on error)
//   instr_err_o       bus error, qualified by instr_rvalid_o
//   gnt_delay_i       cycles from request to grant
//   rvalid_delay_i    extra cycles a response waits at the queue head
//   mem_req_o         SRAM read enable
//   mem_addr_o        SRAM word address
//   mem_rdata_i       SRAM read data, valid the cycle after mem_req_o
//   busy_o            at least one transaction outstanding

module cv32e40p_obi_instr_responder #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_req_i,
  input  logic [31:0]           instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  output logic                  instr_err_o,
  input  logic [3:0]            gnt_delay_i,
  input  logic [3:0]            rvalid_delay_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [31:0]           mem_rdata_i,
  output logic                  busy_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [32:0]   MEM_BYTES = 33'd1 << (ADDR_WIDTH + 2);
  localparam logic [32:0]   BASE_EXT  = {1'b0, BASE_ADDR};

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } gnt_state_e;

  gnt_state_e      state;
  logic [3:0]      cnt;
  logic            gnt_raw;
  logic            gnt;
  logic            room;
  logic            xfer;

  logic [32:0]     addr_ext;
  logic [32:0]     offset;
  logic            in_range;

  logic            stage_valid;
  logic            stage_err;
  logic [32:0]     stage_entry;

  logic [32:0]     q_data [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   q_count;
  logic            q_empty;
  logic [3:0]      head_wait;

  logic            head_ready;
  logic            bypass;
  logic            rvalid;
  logic [32:0]     resp;
  logic            push;
  logic            pop;
  logic            new_head;

  logic [CW-1:0]   outstanding;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // 33-bit range arithmetic so addresses near 2^32 cannot wrap into the window
  assign addr_ext   = {1'b0, instr_addr_i & 32'hFFFF_FFFC};
  assign offset     = addr_ext - BASE_EXT;
  assign in_range   = (addr_ext >= BASE_EXT) && (offset < MEM_BYTES);
  assign mem_addr_o = offset[ADDR_WIDTH+1:2];

  // Response side: the queue head is released once it has waited long enough.
  // An empty queue with zero delay lets the SRAM-stage entry go straight out.
  // ">=" rather than "==" keeps a head from stalling if rvalid_delay_i is
  // lowered below the current wait count.
  assign q_empty     = (q_count == '0);
  assign stage_entry = {stage_err, stage_err ? 32'h0 : mem_rdata_i};
  assign head_ready  = !q_empty && (head_wait >= rvalid_delay_i);
  assign bypass      = q_empty && stage_valid && (rvalid_delay_i == 4'd0);
  assign rvalid      = head_ready || bypass;
  assign resp        = head_ready ? q_data[rd_ptr] : stage_entry;
  assign push        = stage_valid && !bypass;
  assign pop         = head_ready;
  assign new_head    = (q_empty && push) || (pop && ((q_count > CW'(1)) || push));

  // A response leaving this cycle frees a slot, so a grant may reuse it at once
  assign room = (outstanding < DEPTH_C) || rvalid;

  always_comb begin
    gnt_raw = 1'b0;
    if (instr_req_i && room) begin
      case (state)
        S_IDLE:  gnt_raw = (gnt_delay_i == 4'd0);
        S_WAIT:  gnt_raw = (cnt <= 4'd1);
        default: gnt_raw = 1'b0;
      endcase
    end
  end

  // Grant is combinational from registered state; gating with rst_n keeps it
  // (and the SRAM enable) low while reset is held even if a request is present
  assign gnt  = gnt_raw && rst_n;
  assign xfer = instr_req_i && gnt;

  // Grant FSM. cnt counts down in WAIT; the grant lands on the cycle the
  // decrement would reach zero, giving exactly gnt_delay_i cycles of latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_req_i && room && (gnt_delay_i != 4'd0)) begin
            state <= S_WAIT;
            cnt   <= gnt_delay_i;
          end
        end
        S_WAIT: begin
          if (!instr_req_i || gnt_raw) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  // SRAM stage: remembers a transfer for one cycle while the read completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_err   <= 1'b0;
    end else begin
      stage_valid <= xfer;
      stage_err   <= xfer && !in_range;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) q_data[i] <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      q_count   <= '0;
      head_wait <= 4'd0;
    end else begin
      if (push) begin
        q_data[wr_ptr] <= stage_entry;
        wr_ptr         <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      q_count <= q_count + CW'(push) - CW'(pop);
      if (new_head || q_empty) head_wait <= 4'd0;
      else if (head_wait != 4'hF) head_wait <= head_wait + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({xfer, rvalid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = rvalid;
  assign instr_rdata_o  = rvalid ? resp[31:0] : 32'h0;
  assign instr_err_o    = rvalid && resp[32];
  assign mem_req_o      = xfer && in_range;
  assign busy_o         = (outstanding != '0);

endmodule

// File: tb/tb_cv32e40p_obi_instr_responder.sv
// Directed testbench for cv32e40p_obi_instr_responder (default parameters:
// ADDR_WIDTH 14, BASE_ADDR 0, DEPTH 2). The SRAM model returns
// 32'hA500_0000 | word_address one cycle after a read enable.

module tb_cv32e40p_obi_instr_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        instr_err;
  logic [3:0]  gnt_delay;
  logic [3:0]  rvalid_delay;
  logic        mem_req;
  logic [13:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        busy;

  int passed = 0;
  int total  = 0;

  logic        s_gnt, s_rvalid, s_err, s_mem_req, s_busy;
  logic [31:0] s_rdata;
  logic [13:0] s_mem_addr;

  cv32e40p_obi_instr_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_req_i    (instr_req),
    .instr_addr_i   (instr_addr),
    .instr_gnt_o    (instr_gnt),
    .instr_rvalid_o (instr_rvalid),
    .instr_rdata_o  (instr_rdata),
    .instr_err_o    (instr_err),
    .gnt_delay_i    (gnt_delay),
    .rvalid_delay_i (rvalid_delay),
    .mem_req_o      (mem_req),
    .mem_addr_o     (mem_addr),
    .mem_rdata_i    (mem_rdata),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req) mem_rdata <= 32'hA500_0000 | {18'h0, mem_addr};
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] word(input logic [31:0] byte_addr);
    return 32'hA500_0000 | (byte_addr >> 2);
  endfunction

  task automatic applyStimulus(input logic req, input logic [31:0] addr);
    instr_req  = req;
    instr_addr = addr;
  endtask

  // Sample outputs mid-cycle, then move to just after the next rising edge
  task automatic advanceCycle();
    @(negedge clk);
    s_gnt      = instr_gnt;
    s_rvalid   = instr_rvalid;
    s_rdata    = instr_rdata;
    s_err      = instr_err;
    s_mem_req  = mem_req;
    s_mem_addr = mem_addr;
    s_busy     = busy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  bit exp_gnt [14] = '{1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
  bit exp_rv  [14] = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};

  initial begin
    logic [31:0] next_addr;
    int          rsp_idx;

    rst_n        = 1'b0;
    gnt_delay    = 4'd0;
    rvalid_delay = 4'd0;
    applyStimulus(1'b1, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    advanceCycle();
    checkOutput("rst_gnt",     {31'h0, s_gnt},     32'h0);
    checkOutput("rst_mem_req", {31'h0, s_mem_req}, 32'h0);
    checkOutput("rst_rvalid",  {31'h0, s_rvalid},  32'h0);
    checkOutput("rst_rdata",   s_rdata,            32'h0);
    checkOutput("rst_err",     {31'h0, s_err},     32'h0);
    checkOutput("rst_busy",    {31'h0, s_busy},    32'h0);
    applyStimulus(1'b0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] zero-latency back-to-back");
    applyStimulus(1'b1, 32'h0);
    advanceCycle();
    checkOutput("b2b_gnt0",    {31'h0, s_gnt},     32'h1);
    checkOutput("b2b_memreq0", {31'h0, s_mem_req}, 32'h1);
    checkOutput("b2b_memaddr0", {18'h0, s_mem_addr}, 32'h0);
    checkOutput("b2b_rv0",     {31'h0, s_rvalid},  32'h0);
    applyStimulus(1'b1, 32'h4);
    advanceCycle();
    checkOutput("b2b_gnt1",    {31'h0, s_gnt},     32'h1);
    checkOutput("b2b_rv1",     {31'h0, s_rvalid},  32'h1);
    checkOutput("b2b_data1",   s_rdata,            word(32'h0));
    checkOutput("b2b_err1",    {31'h0, s_err},     32'h0);
    applyStimulus(1'b1, 32'h8);
    advanceCycle();
    checkOutput("b2b_gnt2",    {31'h0, s_gnt},     32'h1);
    checkOutput("b2b_rv2",     {31'h0, s_rvalid},  32'h1);
    checkOutput("b2b_data2",   s_rdata,            word(32'h4));
    applyStimulus(1'b0, 32'h0);
    advanceCycle();
    checkOutput("b2b_gnt3",    {31'h0, s_gnt},     32'h0);
    checkOutput("b2b_rv3",     {31'h0, s_rvalid},  32'h1);
    checkOutput("b2b_data3",   s_rdata,            word(32'h8));
    advanceCycle();
    checkOutput("b2b_rv4",     {31'h0, s_rvalid},  32'h0);
    checkOutput("b2b_data4",   s_rdata,            32'h0);
    checkOutput("b2b_busy4",   {31'h0, s_busy},    32'h0);

    $display("[TB] grant delay 3");
    gnt_delay = 4'd3;
    applyStimulus(1'b1, 32'h40);
    for (int i = 0; i < 3; i++) begin
      advanceCycle();
      checkOutput($sformatf("gd_gnt%0d", i), {31'h0, s_gnt}, 32'h0);
    end
    advanceCycle();
    checkOutput("gd_gnt3", {31'h0, s_gnt},    32'h1);
    checkOutput("gd_rv3",  {31'h0, s_rvalid}, 32'h0);
    applyStimulus(1'b0, 32'h0);
    advanceCycle();
    checkOutput("gd_rv4",   {31'h0, s_rvalid}, 32'h1);
    checkOutput("gd_data4", s_rdata,           word(32'h40));
    gnt_delay = 4'd0;
    advanceCycle();

    $display("[TB] response delay 2 with DEPTH 2 back-pressure");
    rvalid_delay = 4'd2;
    next_addr    = 32'h100;
    rsp_idx      = 0;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(i < 8, next_addr);
      advanceCycle();
      checkOutput($sformatf("rd_gnt%0d", i), {31'h0, s_gnt},    {31'h0, exp_gnt[i]});
      checkOutput($sformatf("rd_rv%0d", i),  {31'h0, s_rvalid}, {31'h0, exp_rv[i]});
      if (exp_rv[i]) begin
        checkOutput($sformatf("rd_data%0d", i), s_rdata, word(32'h100 + 32'(rsp_idx * 4)));
        rsp_idx++;
      end
      if (i > 0) checkOutput($sformatf("rd_busy%0d", i), {31'h0, s_busy}, 32'h1);
      if (s_gnt) next_addr = next_addr + 32'h4;
    end
    applyStimulus(1'b0, 32'h0);
    advanceCycle();
    checkOutput("rd_rv_end",   {31'h0, s_rvalid}, 32'h0);
    checkOutput("rd_busy_end", {31'h0, s_busy},   32'h0);
    rvalid_delay = 4'd0;

    $display("[TB] out-of-range fetches");
    applyStimulus(1'b1, 32'h0001_0000);
    advanceCycle();
    checkOutput("oor_gnt0",    {31'h0, s_gnt},     32'h1);
    checkOutput("oor_memreq0", {31'h0, s_mem_req}, 32'h0);
    applyStimulus(1'b1, 32'h20);
    advanceCycle();
    checkOutput("oor_memreq1",  {31'h0, s_mem_req}, 32'h1);
    checkOutput("oor_memaddr1", {18'h0, s_mem_addr}, 32'h8);
    checkOutput("oor_rv1",      {31'h0, s_rvalid},  32'h1);
    checkOutput("oor_err1",     {31'h0, s_err},     32'h1);
    checkOutput("oor_data1",    s_rdata,            32'h0);
    applyStimulus(1'b1, 32'hFFFF_FFFC);
    advanceCycle();
    checkOutput("oor_gnt2",    {31'h0, s_gnt},     32'h1);
    checkOutput("oor_memreq2", {31'h0, s_mem_req}, 32'h0);
    checkOutput("oor_err2",    {31'h0, s_err},     32'h0);
    checkOutput("oor_data2",   s_rdata,            word(32'h20));
    applyStimulus(1'b1, 32'h0000_FFFC);
    advanceCycle();
    checkOutput("oor_memreq3",  {31'h0, s_mem_req}, 32'h1);
    checkOutput("oor_memaddr3", {18'h0, s_mem_addr}, 32'h3FFF);
    checkOutput("oor_err3",     {31'h0, s_err},     32'h1);
    checkOutput("oor_data3",    s_rdata,            32'h0);
    applyStimulus(1'b0, 32'h0);
    advanceCycle();
    checkOutput("oor_rv4",   {31'h0, s_rvalid}, 32'h1);
    checkOutput("oor_err4",  {31'h0, s_err},    32'h0);
    checkOutput("oor_data4", s_rdata,           32'hA500_3FFF);
    advanceCycle();

    $display("[TB] reset with two outstanding");
    rvalid_delay = 4'd2;
    applyStimulus(1'b1, 32'h30);
    advanceCycle();
    applyStimulus(1'b1, 32'h34);
    advanceCycle();
    applyStimulus(1'b1, 32'h38);
    #1;
    checkOutput("mr_busy_pre", {31'h0, busy}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_gnt",    {31'h0, instr_gnt},    32'h0);
    checkOutput("mr_busy",   {31'h0, busy},         32'h0);
    checkOutput("mr_rvalid", {31'h0, instr_rvalid}, 32'h0);
    checkOutput("mr_memreq", {31'h0, mem_req},      32'h0);
    applyStimulus(1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n        = 1'b1;
    rvalid_delay = 4'd0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      advanceCycle();
      checkOutput($sformatf("mr_stale%0d", i), {31'h0, s_rvalid}, 32'h0);
    end
    applyStimulus(1'b1, 32'h3C);
    advanceCycle();
    checkOutput("mr_gnt_new", {31'h0, s_gnt}, 32'h1);
    applyStimulus(1'b0, 32'h0);
    advanceCycle();
    checkOutput("mr_rv_new",   {31'h0, s_rvalid}, 32'h1);
    checkOutput("mr_data_new", s_rdata,           word(32'h3C));

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
